galvo_scan_spi: RTL and testbench
=================================

Name: galvo_scan_spi

Overview:
- Responder to the master controller's `galvo_go` strobe, in the `clk_adc` domain.
- On each accepted `galvo_go` it advances the raster (H,V) scan position and serialises two 24-bit DAC write frames (H then V) to the galvo DAC over SPI.
- It then returns a one-cycle `galvo_spi_done`, and publishes the current `galvoh`/`galvov` position for status readback.

Parameters:
- CLK_DIV, 2, SCLK half-period in `clk_adc` cycles (≥1).
- CS_GAP, 4, cycles `galvo_csn` is held high between/after frames (≥1).
- CMD, 4'b0011, DAC command nibble (write-and-update).

Ports:
- clk_adc  in  1  block clock.
- rst_adc_n  in  1  asynchronous active-low reset.
- galvo_go  in  1  one-cycle step request from the master controller.
- scan_en  in  1  level; when 0, `galvo_go` is ignored.
- scan_restart  in  1  pulse; next accepted step outputs (0,0).
- h_max  in  11  last H index of a line.
- v_max  in  11  last V index of a frame.
- overrun_clr  in  1  pulse; clears `overrun`.
- galvo_sclk  out  1  SPI clock, idle low.
- galvo_mosi  out  1  SPI data, MSB first.
- galvo_csn  out  1  SPI chip select, active low.
- galvoh  out  11  current H position.
- galvov  out  11  current V position.
- galvo_spi_done  out  1  one-cycle pulse, both frames sent.
- frame_done  out  1  one-cycle pulse coincident with `galvo_spi_done` when the step wrapped V to 0.
- busy  out  1  high from acceptance until `galvo_spi_done`.
- overrun  out  1  sticky; `galvo_go` arrived while busy.

Behaviour:
- Reset (async, immediate, including mid-frame) drives:
  - `galvo_csn`=1, `galvo_sclk`=0, `galvo_mosi`=0;
  - `galvoh`=`galvov`=0;
  - `galvo_spi_done`=`frame_done`=`busy`=`overrun`=0;
  - first_pending=1; FSM to IDLE.
- Acceptance: `galvo_go`=1 and `scan_en`=1 and state IDLE. The accepting edge updates the position and `busy`<=1.
- Position update at acceptance:
  - If first_pending: (0,0), first_pending<=0.
  - Else if `galvoh` ≥ `h_max`: H<=0. Then, if `galvov` ≥ `v_max`, V<=0 and wrap flag<=1; else V<=V+1.
  - Else H<=H+1.
  - ≥ comparisons, so a shrinking `h_max`/`v_max` wraps on the next step. `h_max`/`v_max` are sampled at acceptance only.
- `scan_restart` sets first_pending at any time, and never aborts a transfer in progress. Restart coincident with acceptance: the restart wins, so that step outputs (0,0).
- `galvo_go` while not IDLE: dropped, `overrun`<=1. Set has priority over a simultaneous `overrun_clr`.
- `galvo_go` with `scan_en`=0: ignored, no overrun.
- Frame word: {CMD, 3'b000, addr, position[10:0], 5'b00000}, with addr 0 for H and 1 for V.
- FSM states: IDLE -> SETUP -> SHIFT -> GAP -> (SETUP for V | DONE) -> IDLE.
  - SETUP (CLK_DIV cycles): `galvo_csn`=0, `galvo_mosi`=bit23, `galvo_sclk`=0.
  - SHIFT: 24 bits. Each bit is SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles. MOSI changes only on the SCLK falling transition; the DAC samples on the rising edge (mode 0).
  - After bit0's high phase: SCLK<=0, CSN<=1, enter GAP for CS_GAP cycles.
  - After the H frame GAP -> SETUP (V frame). After the V frame GAP -> DONE.
  - DONE (1 cycle): `galvo_spi_done`=1, `frame_done`=wrap flag, `busy`<=0, wrap flag cleared, then IDLE.
- Latency: `galvo_spi_done` is high exactly 2*(CLK_DIV*49+CS_GAP)+1 cycles after the accepting edge. With defaults this is 205.
- A new `galvo_go` in the cycle immediately after DONE is accepted.
- `galvoh`/`galvov` are stable from acceptance through the next acceptance.

Optional Feature:
- GALVO_BIDIR_EN defined: serpentine scan.
  - A direction bit, reset to 0 and set to 0 by an accepted restart step, toggles at each line wrap.
  - On odd lines H decrements, and the line ends when H==0. The next step then goes to V+1 with H held at 0 (the new line starts at 0 going up, or at `h_max` going down, per direction).
  - Precisely: on a reverse line, the line-end step sets H<=0 and flips direction to forward. On a forward line, the line-end step sets H<=`h_max` and flips direction to reverse.
  - V wrap forces direction to 0 and H to 0.
- GALVO_BIDIR_EN undefined: raster scan only, as above; no direction logic present.

Test Plan:
- Reset, then `scan_en`=1, `h_max`=2, `v_max`=1, 7 `galvo_go` pulses spaced 300 cycles -> positions (0,0),(1,0),(2,0),(0,1),(1,1),(2,1),(0,0); `frame_done` only on the 7th step.
- Single step after reset, defaults -> SPI monitor decodes H frame 0x300000 then V frame 0x310000; CSN high 4 cycles between frames; `galvo_spi_done` 205 cycles after acceptance.
- `galvo_go` 50 cycles into a transfer -> position unchanged, `overrun`=1. Then `overrun_clr` -> `overrun`=0.
- Mid-line (H=5) pulse `scan_restart` while busy -> current transfer completes with H=5; next step outputs (0,0).
- Assert `rst_adc_n`=0 during bit 10 of the V frame -> CSN=1, SCLK=0, busy=0 immediately. A post-reset step outputs (0,0).
- GALVO_BIDIR_EN, `h_max`=2, `v_max`=2, 7 steps -> (0,0),(1,0),(2,0),(2,1),(1,1),(0,1),(0,2).

Source files
------------

// File: rtl/galvo_scan_spi.sv
// Galvo scan stepper: on each accepted galvo_go, advances the (H,V) scan position and sends H then V 24-bit DAC frames over SPI mode 0.
// Define GALVO_BIDIR_EN for serpentine scanning; the default build is a plain raster scan.
module galvo_scan_spi #(
   parameter int         CLK_DIV = 2,
   parameter int         CS_GAP  = 4,
   parameter logic [3:0] CMD     = 4'b0011
) (
   input  logic        clk_adc,
   input  logic        rst_adc_n,
   input  logic        galvo_go,
   input  logic        scan_en,
   input  logic        scan_restart,
   input  logic [10:0] h_max,
   input  logic [10:0] v_max,
   input  logic        overrun_clr,
   output logic        galvo_sclk,
   output logic        galvo_mosi,
   output logic        galvo_csn,
   output logic [10:0] galvoh,
   output logic [10:0] galvov,
   output logic        galvo_spi_done,
   output logic        frame_done,
   output logic        busy,
   output logic        overrun
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int            CW     = 16;
   localparam logic [CW-1:0] DIV_LD = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LD = CW'(CS_GAP - 1);

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [4:0]    bit_cnt;
   logic          phase;
   logic          frame_v;
   logic [22:0]   sreg;
   logic          first_pending;
   logic          wrap;
   logic          accept;
   logic [10:0]   nxt_h;
   logic [10:0]   nxt_v;
   logic          nxt_wrap;
   logic [23:0]   word_h;
   logic [23:0]   word_v;

   assign accept = galvo_go && scan_en && (state == S_IDLE);
   assign word_h = {CMD, 3'b000, 1'b0, nxt_h, 5'b00000};
   assign word_v = {CMD, 3'b000, 1'b1, galvov, 5'b00000};

`ifdef GALVO_BIDIR_EN
   logic dir;
   logic nxt_dir;

   // Serpentine: reverse lines count down and end at H==0; a line change holds H at the line's new start.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can leave one unassigned (no latch).
      nxt_h    = galvoh;
      nxt_v    = galvov;
      nxt_wrap = 1'b0;
      nxt_dir  = dir;
      if (first_pending || scan_restart) begin
         nxt_h   = 11'd0;
         nxt_v   = 11'd0;
         nxt_dir = 1'b0;
      end else if (dir ? (galvoh == 11'd0) : (galvoh >= h_max)) begin
         if (galvov >= v_max) begin
            nxt_h    = 11'd0;
            nxt_v    = 11'd0;
            nxt_wrap = 1'b1;
            nxt_dir  = 1'b0;
         end else begin
            nxt_v   = galvov + 11'd1;
            nxt_h   = dir ? 11'd0 : h_max;
            nxt_dir = ~dir;
         end
      end else if (dir) begin
         nxt_h = galvoh - 11'd1;
      end else begin
         nxt_h = galvoh + 11'd1;
      end
   end

   always_ff @(posedge clk_adc or negedge rst_adc_n) begin
      if (!rst_adc_n)  dir <= 1'b0;
      else if (accept) dir <= nxt_dir;
   end
`else
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can leave one unassigned (no latch).
      nxt_h    = galvoh;
      nxt_v    = galvov;
      nxt_wrap = 1'b0;
      if (first_pending || scan_restart) begin
         nxt_h = 11'd0;
         nxt_v = 11'd0;
      end else if (galvoh >= h_max) begin
         nxt_h = 11'd0;
         if (galvov >= v_max) begin
            nxt_v    = 11'd0;
            nxt_wrap = 1'b1;
         end else begin
            nxt_v = galvov + 11'd1;
         end
      end else begin
         nxt_h = galvoh + 11'd1;
      end
   end
`endif

   // Position, handshake and status flags.
   always_ff @(posedge clk_adc or negedge rst_adc_n) begin
      if (!rst_adc_n) begin
         galvoh         <= 11'd0;
         galvov         <= 11'd0;
         first_pending  <= 1'b1;
         wrap           <= 1'b0;
         busy           <= 1'b0;
         galvo_spi_done <= 1'b0;
         frame_done     <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
         galvo_spi_done <= 1'b0;
         frame_done     <= 1'b0;
         if (accept) begin
            galvoh        <= nxt_h;
            galvov        <= nxt_v;
            wrap          <= nxt_wrap;
            busy          <= 1'b1;
            first_pending <= 1'b0;
         end else if (scan_restart) begin
            first_pending <= 1'b1;
         end
         if (state == S_DONE) begin
            galvo_spi_done <= 1'b1;
            frame_done     <= wrap;
            wrap           <= 1'b0;
            busy           <= 1'b0;
         end
         if (galvo_go && scan_en && (state != S_IDLE)) overrun <= 1'b1;
         else if (overrun_clr)                         overrun <= 1'b0;
      end
   end

   // SPI sequencer: two frames (H, V), each SETUP -> 24 bits -> CS gap, then DONE.
   always_ff @(posedge clk_adc or negedge rst_adc_n) begin
      if (!rst_adc_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         bit_cnt    <= 5'd0;
         phase      <= 1'b0;
         frame_v    <= 1'b0;
         sreg       <= '0;
         galvo_csn  <= 1'b1;
         galvo_sclk <= 1'b0;
         galvo_mosi <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state      <= S_SETUP;
                  cnt        <= DIV_LD;
                  frame_v    <= 1'b0;
                  galvo_csn  <= 1'b0;
                  galvo_mosi <= word_h[23];
                  sreg       <= word_h[22:0];
               end
            end
            S_SETUP: begin
               if (cnt == '0) begin
                  state   <= S_SHIFT;
                  cnt     <= DIV_LD;
                  phase   <= 1'b0;
                  bit_cnt <= 5'd23;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_SHIFT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (!phase) begin
                  cnt        <= DIV_LD;
                  phase      <= 1'b1;
                  galvo_sclk <= 1'b1;
               end else begin
                  cnt        <= DIV_LD;
                  phase      <= 1'b0;
                  galvo_sclk <= 1'b0;
                  if (bit_cnt == 5'd0) begin
                     state      <= S_GAP;
                     cnt        <= GAP_LD;
                     galvo_csn  <= 1'b1;
                     galvo_mosi <= 1'b0;
                  end else begin
                     bit_cnt    <= bit_cnt - 1'b1;
                     galvo_mosi <= sreg[22];
                     sreg       <= {sreg[21:0], 1'b0};
                  end
               end
            end
            S_GAP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (!frame_v) begin
                  state      <= S_SETUP;
                  cnt        <= DIV_LD;
                  frame_v    <= 1'b1;
                  galvo_csn  <= 1'b0;
                  galvo_mosi <= word_v[23];
                  sreg       <= word_v[22:0];
               end else begin
                  state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_galvo_scan_spi.sv
// Self-checking bench for galvo_scan_spi: directed table, hand-written corner sequences and randomized steps against a scan-index model.
module tb_galvo_scan_spi;

   localparam int         CLK_DIV = 2;
   localparam int         CS_GAP  = 4;
   localparam logic [3:0] CMD     = 4'b0011;
   localparam int         LAT     = 2 * (CLK_DIV * 49 + CS_GAP) + 1;

   logic        clk = 1'b0;
   logic        rst_adc_n;
   logic        galvo_go, scan_en, scan_restart, overrun_clr;
   logic [10:0] h_max, v_max;
   logic        galvo_sclk, galvo_mosi, galvo_csn;
   logic [10:0] galvoh, galvov;
   logic        galvo_spi_done, frame_done, busy, overrun;

   always #5 clk = ~clk;

   galvo_scan_spi #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .CMD(CMD)) dut (
      .clk_adc(clk), .rst_adc_n(rst_adc_n), .galvo_go(galvo_go), .scan_en(scan_en),
      .scan_restart(scan_restart), .h_max(h_max), .v_max(v_max), .overrun_clr(overrun_clr),
      .galvo_sclk(galvo_sclk), .galvo_mosi(galvo_mosi), .galvo_csn(galvo_csn),
      .galvoh(galvoh), .galvov(galvov), .galvo_spi_done(galvo_spi_done),
      .frame_done(frame_done), .busy(busy), .overrun(overrun)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // SPI monitor: frames are recorded as {bit_count, 24-bit word}.
   logic [31:0] frames[$];
   logic [23:0] sh = '0;
   int          nb = 0, hi_run = 0, last_gap = 0, mosi_viol = 0;
   logic        sclk_q = 1'b0, csn_q = 1'b1, mosi_q = 1'b0;

   always @(negedge clk) begin
      if (!galvo_csn && galvo_sclk && !sclk_q) begin
         sh = {sh[22:0], galvo_mosi};
         nb++;
      end
      if (!galvo_csn && !csn_q && (galvo_mosi != mosi_q) && !(sclk_q && !galvo_sclk)) mosi_viol++;
      if (csn_q && !galvo_csn) begin
         nb = 0;
         sh = '0;
         last_gap = hi_run;
      end
      if (!csn_q && galvo_csn) frames.push_back({nb[7:0], sh});
      hi_run = galvo_csn ? hi_run + 1 : 0;
      sclk_q = galvo_sclk;
      csn_q  = galvo_csn;
      mosi_q = galvo_mosi;
   end

   // Reference model: the scan is a linear step index k over (h_max+1)*(v_max+1) points.
   int          m_k = 0;
   bit          m_first = 1'b1;
   logic [10:0] exp_h, exp_v;
   logic        exp_fd;

   task automatic model_step(input logic rs);
      int w, n, line, col;
      w = int'(h_max) + 1;
      n = w * (int'(v_max) + 1);
      if (m_first || rs) begin
         m_k = 0;
         m_first = 1'b0;
         exp_fd = 1'b0;
      end else begin
         m_k = (m_k + 1) % n;
         exp_fd = (m_k == 0);
      end
      line = m_k / w;
      col  = m_k % w;
`ifdef GALVO_BIDIR_EN
      exp_h = 11'((line % 2 == 1) ? int'(h_max) - col : col);
`else
      exp_h = 11'(col);
`endif
      exp_v = 11'(line);
   endtask

   function automatic logic [31:0] exp_frame(input logic addr, input logic [10:0] pos);
      return {8'd24, CMD, 3'b000, addr, pos, 5'b00000};
   endfunction

   // One step: pulse galvo_go (with optional restart); mid selects an event 50 cycles into the transfer:
   // 1 = go (overrun), 2 = restart, 3 = go + overrun_clr, 5 = go with scan_en low.
   task automatic run_step(input logic en, input logic rs, input int mid);
      logic [10:0] h0, v0;
      int          lat, fbase;
      h0 = galvoh;
      v0 = galvov;
      fbase = frames.size();
      galvo_go = 1'b1; scan_en = en; scan_restart = rs;
      @(posedge clk); #1;
      galvo_go = 1'b0; scan_restart = 1'b0; scan_en = 1'b1;
      if (!en) begin
         if (rs) m_first = 1'b1;
         check("idle_busy", busy, 0);
         check("idle_h", galvoh, h0);
         check("idle_v", galvov, v0);
         return;
      end
      model_step(rs);
      check("acc_busy", busy, 1);
      check("acc_h", galvoh, exp_h);
      check("acc_v", galvov, exp_v);
      lat = 0;
      while (!galvo_spi_done && lat < 400) begin
         if (lat == 50) begin
            case (mid)
               1: galvo_go = 1'b1;
               2: begin scan_restart = 1'b1; m_first = 1'b1; end
               3: begin galvo_go = 1'b1; overrun_clr = 1'b1; end
               5: begin galvo_go = 1'b1; scan_en = 1'b0; end
               default: ;
            endcase
         end
         @(posedge clk); #1;
         lat++;
         galvo_go = 1'b0; scan_restart = 1'b0; overrun_clr = 1'b0; scan_en = 1'b1;
         if (lat == 51 && mid != 0 && mid != 2) check("overrun_mid", overrun, (mid == 5) ? 0 : 1);
      end
      check("latency", lat, LAT);
      check("done_h", galvoh, exp_h);
      check("done_v", galvov, exp_v);
      check("frame_done", frame_done, exp_fd);
      check("done_busy", busy, 0);
      check("frame_cnt", frames.size() - fbase, 2);
      if (frames.size() >= fbase + 2) begin
         check("frame_h", frames[fbase], exp_frame(1'b0, exp_h));
         check("frame_v", frames[fbase + 1], exp_frame(1'b1, exp_v));
      end
   endtask

   typedef struct {
      logic        en;
      logic        rs;
      logic [10:0] h;
      logic [10:0] v;
      logic        fd;
   } vec_t;

   function automatic vec_t mk(input logic en, input logic rs, input int h, input int v, input logic fd);
      vec_t r;
      r.en = en; r.rs = rs; r.h = 11'(h); r.v = 11'(v); r.fd = fd;
      return r;
   endfunction

   vec_t tbl[10];

   initial begin
      rst_adc_n = 1'b1;
      galvo_go = 1'b0; scan_en = 1'b1; scan_restart = 1'b0; overrun_clr = 1'b0;
`ifdef GALVO_BIDIR_EN
      h_max = 11'd2; v_max = 11'd2;
      tbl[0] = mk(1, 0, 0, 0, 0); tbl[1] = mk(1, 0, 1, 0, 0); tbl[2] = mk(1, 0, 2, 0, 0);
      tbl[3] = mk(1, 0, 2, 1, 0); tbl[4] = mk(1, 0, 1, 1, 0); tbl[5] = mk(1, 0, 0, 1, 0);
      tbl[6] = mk(1, 0, 0, 2, 0); tbl[7] = mk(0, 0, 0, 2, 0); tbl[8] = mk(1, 0, 1, 2, 0);
      tbl[9] = mk(1, 1, 0, 0, 0);
`else
      h_max = 11'd2; v_max = 11'd1;
      tbl[0] = mk(1, 0, 0, 0, 0); tbl[1] = mk(1, 0, 1, 0, 0); tbl[2] = mk(1, 0, 2, 0, 0);
      tbl[3] = mk(1, 0, 0, 1, 0); tbl[4] = mk(1, 0, 1, 1, 0); tbl[5] = mk(1, 0, 2, 1, 0);
      tbl[6] = mk(1, 0, 0, 0, 1); tbl[7] = mk(0, 0, 0, 0, 0); tbl[8] = mk(1, 0, 1, 0, 0);
      tbl[9] = mk(1, 1, 0, 0, 0);
`endif
      #2 rst_adc_n = 1'b0;
      #10;
      check("rst_csn", galvo_csn, 1);
      check("rst_sclk", galvo_sclk, 0);
      check("rst_mosi", galvo_mosi, 0);
      check("rst_pos", {galvoh, galvov}, 0);
      check("rst_flags", {galvo_spi_done, frame_done, busy, overrun}, 0);
      @(posedge clk); #1 rst_adc_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         run_step(tbl[i].en, tbl[i].rs, 0);
         check($sformatf("tbl%0d_h", i), galvoh, tbl[i].h);
         check($sformatf("tbl%0d_v", i), galvov, tbl[i].v);
         check($sformatf("tbl%0d_fd", i), frame_done, tbl[i].fd);
         if (i == 0) check("cs_gap", last_gap, CS_GAP);
      end

      // Overrun: set while busy, sticky, cleared by overrun_clr; set beats clear; ignored when scan_en=0.
      h_max = 11'd7; v_max = 11'd3;
      run_step(1, 1, 0);
      run_step(1, 0, 1);
      check("ovr_sticky", overrun, 1);
      overrun_clr = 1'b1; @(posedge clk); #1; overrun_clr = 1'b0;
      check("ovr_clr", overrun, 0);
      run_step(1, 0, 3);
      check("ovr_set_wins", overrun, 1);
      overrun_clr = 1'b1; @(posedge clk); #1; overrun_clr = 1'b0;
      run_step(1, 0, 5);
      check("ovr_en0", overrun, 0);

      // Restart mid-transfer at H=5 does not disturb the current step.
      run_step(1, 0, 0);
      run_step(1, 0, 2);
      check("restart_cur_h", galvoh, 5);
      run_step(1, 0, 0);
      check("restart_next_h", galvoh, 0);
      check("restart_next_v", galvov, 0);
      run_step(1, 0, 0);

      // Reset during bit 10 of the V frame.
      galvo_go = 1'b1; @(posedge clk); #1; galvo_go = 1'b0;
      repeat (159) begin @(posedge clk); #1; end
      check("pre_rst_bits", nb, 14);
      check("pre_rst_sclk", galvo_sclk, 1);
      check("pre_rst_busy", busy, 1);
      rst_adc_n = 1'b0; #1;
      check("mid_rst_csn", galvo_csn, 1);
      check("mid_rst_sclk", galvo_sclk, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_pos", {galvoh, galvov}, 0);
      m_first = 1'b1;
      @(posedge clk); #1 rst_adc_n = 1'b1;
      run_step(1, 0, 0);
      check("post_rst_pos", {galvoh, galvov}, 0);

      // Randomized steps against the model.
      for (int s = 0; s < 3; s++) begin
         h_max = 11'($urandom_range(0, 3));
         v_max = 11'($urandom_range(0, 2));
         run_step(1, 1, 0);
         for (int j = 0; j < 8; j++) begin
            run_step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                     ($urandom_range(0, 7) == 0) ? 2 : 0);
         end
      end

      check("mosi_edges", mosi_viol, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
